// File: rtl/alu_cmd_seq.sv
// Command sequencer for an external combinational ALU: reads operands from a
// 4x4 register file, issues them, captures masked results and writes them back.
module alu_cmd_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [1:0] cmd_rd,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [3:0] alu_x,
    input  logic [3:0] alu_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_x,
    output logic [3:0] rsp_y
);
    // state   | meaning
    // IDLE    | waiting for a command (cmd_ready high once out of reset)
    // ISSUE   | ALU operands driven, one settle cycle
    // CAPTURE | ALU results sampled, masked and written back on this edge
    // RESP    | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [3:0] OP_LOADI = 4'b1101;

    state_t     state;
    state_t     state_nxt;
    logic       run_en;
    logic [1:0] rd_q;
    logic [3:0] regs [4];
    logic       accept;
    logic       is_loadi;
    logic [3:0] x_m;
    logic [3:0] y_m;
    logic       y_wr;

    // run_en keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = (state == IDLE) && run_en;
    assign rsp_valid = (state == RESP);

    always_comb begin
        accept    = cmd_valid && cmd_ready;
        is_loadi  = (cmd_op == OP_LOADI);
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_loadi ? RESP : ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result masking keyed on the held opcode
    always_comb begin
        x_m  = alu_x;
        y_m  = 4'b0000;
        y_wr = 1'b0;
        case (alu_opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1000, 4'b1001: x_m = {3'b000, alu_x[0]};
            default: ;
        endcase
        case (alu_opcode)
            4'b1010: begin
                y_m  = {3'b000, alu_y[0]};
                y_wr = 1'b1;
            end
            4'b1100, 4'b1110, 4'b1111: begin
                y_m  = alu_y;
                y_wr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run_en     <= 1'b0;
            rd_q       <= 2'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_opcode <= 4'd0;
            rsp_x      <= 4'd0;
            rsp_y      <= 4'd0;
            regs[0]    <= 4'd0;
            regs[1]    <= 4'd0;
            regs[2]    <= 4'd0;
            regs[3]    <= 4'd0;
        end else begin
            state  <= state_nxt;
            run_en <= 1'b1;
            if (accept) begin
                rd_q <= cmd_rd;
                if (is_loadi) begin
                    regs[cmd_rd] <= cmd_imm;
                    rsp_x        <= cmd_imm;
                    rsp_y        <= 4'd0;
                end else begin
                    alu_a      <= regs[cmd_ra];
                    alu_b      <= regs[cmd_rb];
                    alu_opcode <= cmd_op;
                end
            end
            if (state == CAPTURE) begin
                regs[rd_q] <= x_m;
                if (y_wr) regs[rd_q + 2'd1] <= y_m;
                rsp_x <= x_m;
                rsp_y <= y_m;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Testbench for alu_cmd_seq: directed vector table, stall/reset/back-to-back
// sequences and randomized commands against a behavioural model.
module tb_alu_cmd_seq;
    localparam logic [3:0] LD = 4'b1101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [1:0] cmd_ra = 2'd0;
    logic [1:0] cmd_rb = 2'd0;
    logic [1:0] cmd_rd = 2'd0;
    logic [3:0] cmd_imm = 4'd0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_opcode;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_x;
    logic [3:0] rsp_y;
    logic [3:0] garb = 4'd1;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [3:0] mr [4];
    logic [3:0] ma, mb, mo;

    alu_cmd_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_x(alu_x), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_y(rsp_y)
    );

    always #5 clk = ~clk;

    // Environment ALU; unused result bits carry garbage that must be masked.
    function automatic logic [7:0] alu_fn(logic [3:0] a, logic [3:0] b, logic [3:0] op, logic [3:0] g);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] x;
        logic [3:0] y;
        s = {1'b0, a} + {1'b0, b};
        p = {4'd0, a} * {4'd0, b};
        case (op)
            4'hA:    begin x = s[3:0]; y = {g[2:0], s[4]}; end
            4'hC:    begin x = p[3:0]; y = p[7:4]; end
            4'hE:    begin x = a - b; y = a ^ b; end
            4'hF:    begin x = a & b; y = a | b; end
            4'h9:    begin x = {g[2:0], a == b}; y = g; end
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8:
                     begin x = {g[2:0], (a < b) ^ op[0]}; y = g; end
            default: begin x = a + b + op; y = g; end
        endcase
        return {x, y};
    endfunction

    always_comb begin
        {alu_x, alu_y} = alu_fn(alu_a, alu_b, alu_opcode, garb);
    end

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = 4'd0;
        ma = 4'd0; mb = 4'd0; mo = 4'd0;
    endtask

    // Expected response and register effects derived from the command rules
    task automatic model_cmd(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                             input logic [1:0] rd, input logic [3:0] imm,
                             output logic [3:0] ex, output logic [3:0] ey);
        logic [7:0] r;
        logic       two;
        if (op == LD) begin
            ex = imm; ey = 4'd0;
            mr[rd] = imm;
        end else begin
            ma = mr[ra]; mb = mr[rb]; mo = op;
            r = alu_fn(ma, mb, op, garb);
            if (op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9}) ex = {3'b000, r[4]};
            else ex = r[7:4];
            two = 1'b1;
            if (op == 4'hA) ey = {3'b000, r[0]};
            else if (op inside {4'hC, 4'hE, 4'hF}) ey = r[3:0];
            else begin ey = 4'd0; two = 1'b0; end
            mr[rd] = ex;
            if (two) mr[(int'(rd) + 1) % 4] = ey;
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is first seen.
    task automatic do_cmd(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic [3:0] imm,
                          output logic [3:0] x, output logic [3:0] y, output int lat);
        int n;
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        x = 4'd0; y = 4'd0; lat = -1;
        if (!cmd_ready) begin
            failures++; checks++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            failures++; checks++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0 for %0d cycles, required 1", n);
            return;
        end
        lat = n;
        x = rsp_x; y = rsp_y;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                           input logic [1:0] rd, input logic [3:0] imm,
                           output logic [3:0] x, output logic [3:0] y, output int lat);
        logic [3:0] ex, ey;
        garb = {1'($urandom), 3'($urandom_range(1, 7))};
        model_cmd(op, ra, rb, rd, imm, ex, ey);
        do_cmd(op, ra, rb, rd, imm, x, y, lat);
        chk4("rsp_x", x, ex);
        chk4("rsp_y", y, ey);
        chki("latency", lat, (op == LD) ? 1 : 3);
        chk4("alu_a", alu_a, ma);
        chk4("alu_b", alu_b, mb);
        chk4("alu_opcode", alu_opcode, mo);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] ra, rb, rd;
        logic [3:0] imm;
        logic [3:0] ex, ey;
        logic [1:0] ri0; logic [3:0] rv0;
        logic [1:0] ri1; logic [3:0] rv1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0] x, y, hx, hy;
        logic [3:0] bq_x [$];
        logic [3:0] bq_ex [$];
        logic [3:0] bq_ey [$];
        logic [3:0] bq_y [$];
        int lat, npulse, nrsp, idx;
        logic pend;
        logic [3:0] bop [3];
        logic [1:0] bra [3], brd [3];
        logic [3:0] bimm [3];

        tbl[0] = '{LD,   0, 0, 0, 4'd5, 4'd5, 4'd0, 0, 4'd5, 0, 4'd5};
        tbl[1] = '{LD,   0, 0, 1, 4'd3, 4'd3, 4'd0, 1, 4'd3, 0, 4'd5};
        tbl[2] = '{4'hA, 0, 1, 2, 4'd0, 4'd8, 4'd0, 2, 4'd8, 3, 4'd0};
        tbl[3] = '{LD,   0, 0, 0, 4'd7, 4'd7, 4'd0, 0, 4'd7, 1, 4'd3};
        tbl[4] = '{LD,   0, 0, 1, 4'd3, 4'd3, 4'd0, 1, 4'd3, 0, 4'd7};
        tbl[5] = '{4'hC, 0, 1, 3, 4'd0, 4'd5, 4'd1, 3, 4'd5, 0, 4'd1};
        tbl[6] = '{LD,   0, 0, 0, 4'd9, 4'd9, 4'd0, 0, 4'd9, 3, 4'd5};
        tbl[7] = '{LD,   0, 0, 1, 4'd9, 4'd9, 4'd0, 1, 4'd9, 0, 4'd9};
        tbl[8] = '{4'h9, 0, 1, 2, 4'd0, 4'd1, 4'd0, 2, 4'd1, 3, 4'd5};

        // reset state
        model_reset();
        repeat (3) @(negedge clk);
        chk4("rst_cmd_ready", {3'b0, cmd_ready}, 4'd0);
        chk4("rst_rsp_valid", {3'b0, rsp_valid}, 4'd0);
        chk4("rst_alu_a", alu_a, 4'd0);
        chk4("rst_alu_opcode", alu_opcode, 4'd0);
        chk4("rst_rsp_x", rsp_x, 4'd0);
        for (int i = 0; i < 4; i++) chk4("rst_reg", dut.regs[i], 4'd0);
        rst_n = 1'b1;
        #1 chk4("release_cmd_ready", {3'b0, cmd_ready}, 4'd0);
        @(posedge clk); #1;
        chk4("first_edge_cmd_ready", {3'b0, cmd_ready}, 4'd1);
        @(negedge clk);

        // directed vector table
        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].imm, x, y, lat);
            chk4($sformatf("tbl%0d_x", i), x, tbl[i].ex);
            chk4($sformatf("tbl%0d_y", i), y, tbl[i].ey);
            @(negedge clk);
            chk4($sformatf("tbl%0d_reg_a", i), dut.regs[tbl[i].ri0], tbl[i].rv0);
            chk4($sformatf("tbl%0d_reg_b", i), dut.regs[tbl[i].ri1], tbl[i].rv1);
        end

        // response back-pressure on an ALU command
        rsp_ready = 1'b0;
        run_cmd(4'hC, 0, 1, 2, 4'd0, hx, hy, lat);
        cmd_op = LD; cmd_rd = 2'd3; cmd_imm = 4'hB; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk4("stall_rsp_valid", {3'b0, rsp_valid}, 4'd1);
            chk4("stall_rsp_x", rsp_x, hx);
            chk4("stall_rsp_y", rsp_y, hy);
            chk4("stall_cmd_ready", {3'b0, cmd_ready}, 4'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk4("post_hs_rsp_valid", {3'b0, rsp_valid}, 4'd0);
        chk4("post_hs_cmd_ready", {3'b0, cmd_ready}, 4'd1);
        run_cmd(LD, 0, 0, 3, 4'hB, x, y, lat);
        @(negedge clk);

        // reset during ISSUE abandons the command
        run_cmd(LD, 0, 0, 1, 4'd6, x, y, lat);
        cmd_op = 4'h4; cmd_ra = 2'd1; cmd_rb = 2'd1; cmd_rd = 2'd1; cmd_valid = 1'b1;
        idx = 0;
        while (!cmd_ready && idx < 10) begin @(negedge clk); idx++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk4("issue_alu_a_loaded", alu_a, 4'd6);
        rst_n = 1'b0;
        #1;
        chk4("midrst_alu_a", alu_a, 4'd0);
        chk4("midrst_alu_b", alu_b, 4'd0);
        chk4("midrst_alu_opcode", alu_opcode, 4'd0);
        chk4("midrst_cmd_ready", {3'b0, cmd_ready}, 4'd0);
        chk4("midrst_reg1", dut.regs[1], 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk4("midrst_rsp_valid", {3'b0, rsp_valid}, 4'd0);
        end
        model_reset();
        rst_n = 1'b1;
        #1 chk4("midrst_release_cmd_ready", {3'b0, cmd_ready}, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk4("postrst_rsp_valid", {3'b0, rsp_valid}, 4'd0);
            chk4("postrst_cmd_ready", {3'b0, cmd_ready}, 4'd1);
        end
        chk4("postrst_reg1", dut.regs[1], 4'd0);

        // back-to-back commands with cmd_valid held high
        bop[0] = LD;   bra[0] = 0; brd[0] = 2; bimm[0] = 4'hA;
        bop[1] = 4'hF; bra[1] = 2; brd[1] = 0; bimm[1] = 4'h0;
        bop[2] = LD;   bra[2] = 0; brd[2] = 3; bimm[2] = 4'h4;
        for (int i = 0; i < 3; i++) begin
            model_cmd(bop[i], bra[i], bra[i], brd[i], bimm[i], x, y);
            bq_ex.push_back(x);
            bq_ey.push_back(y);
        end
        npulse = 0; nrsp = 0; idx = 0; pend = 1'b0;
        cmd_op = bop[0]; cmd_ra = bra[0]; cmd_rb = bra[0]; cmd_rd = brd[0]; cmd_imm = bimm[0];
        cmd_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) begin nrsp++; bq_x.push_back(rsp_x); bq_y.push_back(rsp_y); end
            if (cmd_valid && cmd_ready) begin npulse++; pend = 1'b1; end
            @(negedge clk);
            if (pend) begin
                idx++;
                pend = 1'b0;
                if (idx < 3) begin
                    cmd_op = bop[idx]; cmd_ra = bra[idx]; cmd_rb = bra[idx];
                    cmd_rd = brd[idx]; cmd_imm = bimm[idx];
                end else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chki("b2b_accepts", npulse, 3);
        chki("b2b_responses", nrsp, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < bq_x.size()) begin
                chk4($sformatf("b2b_rsp%0d_x", i), bq_x[i], bq_ex[i]);
                chk4($sformatf("b2b_rsp%0d_y", i), bq_y[i], bq_ey[i]);
            end
        end
        for (int i = 0; i < 4; i++) chk4("b2b_reg", dut.regs[i], mr[i]);

        // randomized commands against the model
        for (int n = 0; n < 200; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? LD : 4'($urandom);
            run_cmd(op, 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), x, y, lat);
            if ($urandom_range(0, 3) == 0) begin
                rsp_ready = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                chk4("rnd_stall_x", rsp_x, x);
                rsp_ready = 1'b1;
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) chk4("rnd_reg", dut.regs[i], mr[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
